// File: rtl/constants_pkg.sv
// Shared operation encoding for the ALU / register-file pipeline.
package constants_pkg;

  typedef enum logic [3:0] {
    NOP       = 4'd0,
    REG_READ  = 4'd1,
    REG_WRITE = 4'd2,
    ADD       = 4'd3,
    ADC       = 4'd4,
    SUB       = 4'd5,
    AND       = 4'd6,
    OR        = 4'd7,
    XOR       = 4'd8
  } ALUOp;

endpackage

// File: rtl/alu_regfile_pipe.sv
// Two-stage ALU with register file.
// Issue stage reads operands (with bypass from the execute stage).
// Execute stage updates the register file, the flags and data_out.
module alu_regfile_pipe #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  op_valid,
  input  constants_pkg::ALUOp   op,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [ADDR_W-1:0]     addr_r,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  out_valid,
  output logic                  carry_flag,
  output logic                  zero_flag
);

  import constants_pkg::*;

  // Architectural state
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_data_out;
  logic              r_out_valid;
  logic              r_carry;
  logic              r_zero;

  // Execute-stage pipeline registers
  logic              r_ex_valid;
  ALUOp              r_ex_op;
  logic [ADDR_W-1:0] r_ex_waddr;
  logic [DATA_W-1:0] r_ex_a;
  logic [DATA_W-1:0] r_ex_b;
  logic              r_ex_cin;

  // Execute-stage combinational results
  logic [DATA_W:0]   w_full;
  logic [DATA_W-1:0] w_res;
  logic              w_carry;
  logic              w_zero;
  logic              w_we_raw;
  logic              w_flag_raw;
  logic              w_rd_raw;
  logic              w_ex_we;
  logic              w_ex_flag;
  logic              w_ex_rd;

  // Issue-stage bypassed operands
  logic              w_hit_a;
  logic              w_hit_b;
  logic [DATA_W-1:0] w_opnd_a;
  logic [DATA_W-1:0] w_opnd_b;
  logic              w_cin;

  // Execute-stage datapath: full-width result plus the kind of update it causes
  always_comb begin
    w_full     = {(DATA_W+1){1'b0}};
    w_we_raw   = 1'b0;
    w_flag_raw = 1'b0;
    w_rd_raw   = 1'b0;
    case (r_ex_op)
      REG_WRITE: begin
        w_full   = {1'b0, r_ex_a};
        w_we_raw = 1'b1;
      end
      REG_READ: begin
        w_full   = {1'b0, r_ex_a};
        w_rd_raw = 1'b1;
      end
      ADD: begin
        w_full     = {1'b0, r_ex_a} + {1'b0, r_ex_b};
        w_we_raw   = 1'b1;
        w_flag_raw = 1'b1;
      end
      ADC: begin
        w_full     = {1'b0, r_ex_a} + {1'b0, r_ex_b} + {{DATA_W{1'b0}}, r_ex_cin};
        w_we_raw   = 1'b1;
        w_flag_raw = 1'b1;
      end
      SUB: begin
        // Top bit of the (DATA_W+1)-bit difference is the unsigned borrow.
        w_full     = {1'b0, r_ex_a} - {1'b0, r_ex_b};
        w_we_raw   = 1'b1;
        w_flag_raw = 1'b1;
      end
      AND: begin
        w_full     = {1'b0, r_ex_a & r_ex_b};
        w_we_raw   = 1'b1;
        w_flag_raw = 1'b1;
      end
      OR: begin
        w_full     = {1'b0, r_ex_a | r_ex_b};
        w_we_raw   = 1'b1;
        w_flag_raw = 1'b1;
      end
      XOR: begin
        w_full     = {1'b0, r_ex_a ^ r_ex_b};
        w_we_raw   = 1'b1;
        w_flag_raw = 1'b1;
      end
      default: begin
        w_full     = {(DATA_W+1){1'b0}};
        w_we_raw   = 1'b0;
        w_flag_raw = 1'b0;
        w_rd_raw   = 1'b0;
      end
    endcase
  end

  assign w_res     = w_full[DATA_W-1:0];
  assign w_carry   = w_full[DATA_W];
  assign w_zero    = (w_res == {DATA_W{1'b0}});
  assign w_ex_we   = r_ex_valid & w_we_raw;
  assign w_ex_flag = r_ex_valid & w_flag_raw;
  assign w_ex_rd   = r_ex_valid & w_rd_raw;

  // Forward the value being written this cycle to an op issuing now
  assign w_hit_a  = w_ex_we && (r_ex_waddr == addr_a);
  assign w_hit_b  = w_ex_we && (r_ex_waddr == addr_b);
  assign w_opnd_a = w_hit_a ? w_res : r_regs[addr_a];
  assign w_opnd_b = w_hit_b ? w_res : r_regs[addr_b];
  assign w_cin    = w_ex_flag ? w_carry : r_carry;

  // Issue stage: capture op and bypassed operands at the accepting edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= NOP;
      r_ex_waddr <= {ADDR_W{1'b0}};
      r_ex_a     <= {DATA_W{1'b0}};
      r_ex_b     <= {DATA_W{1'b0}};
      r_ex_cin   <= 1'b0;
    end else begin
      r_ex_valid <= op_valid && (op != NOP);
      r_ex_op    <= op;
      r_ex_waddr <= (op == REG_WRITE) ? addr_a : addr_r;
      r_ex_a     <= (op == REG_WRITE) ? data_in : w_opnd_a;
      r_ex_b     <= w_opnd_b;
      r_ex_cin   <= w_cin;
    end
  end

  // Writeback: only the execute-stage op ever writes the register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (w_ex_we) begin
      r_regs[r_ex_waddr] <= w_res;
    end else begin
      r_regs[r_ex_waddr] <= r_regs[r_ex_waddr];
    end
  end

  // Status flags: updated only by arithmetic/logic ops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_ex_flag) begin
      r_carry <= w_carry;
      r_zero  <= w_zero;
    end else begin
      r_carry <= r_carry;
      r_zero  <= r_zero;
    end
  end

  // Read port: data_out holds until the next REG_READ, out_valid pulses once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out  <= {DATA_W{1'b0}};
      r_out_valid <= 1'b0;
    end else if (w_ex_rd) begin
      r_data_out  <= w_res;
      r_out_valid <= 1'b1;
    end else begin
      r_data_out  <= r_data_out;
      r_out_valid <= 1'b0;
    end
  end

  assign data_out   = r_data_out;
  assign out_valid  = r_out_valid;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed self-checking bench for alu_regfile_pipe (8-bit and 16-bit instances).
module tb_alu_regfile_pipe;

  import constants_pkg::*;

  logic        clk;
  logic        reset_n;

  logic        v8;
  ALUOp        op8;
  logic [2:0]  a8, b8, r8;
  logic [7:0]  din8;
  logic [7:0]  dout8;
  logic        ov8, c8, z8;

  logic        v16;
  ALUOp        op16;
  logic [3:0]  a16, b16, r16;
  logic [15:0] din16;
  logic [15:0] dout16;
  logic        ov16, c16, z16;

  int checks   = 0;
  int failures = 0;

  alu_regfile_pipe #(.DATA_W(8), .NUM_REGS(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .op_valid(v8), .op(op8),
    .addr_a(a8), .addr_b(b8), .addr_r(r8), .data_in(din8),
    .data_out(dout8), .out_valid(ov8), .carry_flag(c8), .zero_flag(z8)
  );

  alu_regfile_pipe #(.DATA_W(16), .NUM_REGS(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .op_valid(v16), .op(op16),
    .addr_a(a16), .addr_b(b16), .addr_r(r16), .data_in(din16),
    .data_out(dout16), .out_valid(ov16), .carry_flag(c16), .zero_flag(z16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op to the 8-bit DUT and return at the negedge after it is accepted
  task automatic do8(input ALUOp o, input logic [2:0] a, input logic [2:0] b,
                     input logic [2:0] r, input logic [7:0] d);
    v8 = 1'b1; op8 = o; a8 = a; b8 = b; r8 = r; din8 = d;
    @(negedge clk);
  endtask

  task automatic idle8();
    v8 = 1'b0; op8 = NOP; a8 = 3'd0; b8 = 3'd0; r8 = 3'd0; din8 = 8'h00;
    @(negedge clk);
  endtask

  task automatic rd8(input logic [2:0] a, input logic [7:0] exp, input string tag);
    do8(REG_READ, a, 3'd0, 3'd0, 8'h00);
    idle8();
    chk(tag, {56'd0, dout8}, {56'd0, exp});
    chk({tag, "_ov"}, {63'd0, ov8}, 64'd1);
  endtask

  task automatic do16(input ALUOp o, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] r, input logic [15:0] d);
    v16 = 1'b1; op16 = o; a16 = a; b16 = b; r16 = r; din16 = d;
    @(negedge clk);
  endtask

  task automatic idle16();
    v16 = 1'b0; op16 = NOP; a16 = 4'd0; b16 = 4'd0; r16 = 4'd0; din16 = 16'h0000;
    @(negedge clk);
  endtask

  task automatic rd16(input logic [3:0] a, input logic [15:0] exp, input string tag);
    do16(REG_READ, a, 4'd0, 4'd0, 16'h0000);
    idle16();
    chk(tag, {48'd0, dout16}, {48'd0, exp});
    chk({tag, "_ov"}, {63'd0, ov16}, 64'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    v8 = 1'b0; op8 = NOP; a8 = 3'd0; b8 = 3'd0; r8 = 3'd0; din8 = 8'h00;
    v16 = 1'b0; op16 = NOP; a16 = 4'd0; b16 = 4'd0; r16 = 4'd0; din16 = 16'h0000;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_dout", {56'd0, dout8}, 64'd0);
    chk("rst_ov", {63'd0, ov8}, 64'd0);
    chk("rst_carry", {63'd0, c8}, 64'd0);
    chk("rst_zero", {63'd0, z8}, 64'd0);
    chk("rst_dout16", {48'd0, dout16}, 64'd0);
    reset_n = 1'b1;

    // Basic sum
    do8(REG_WRITE, 3'd0, 3'd0, 3'd0, 8'h42);
    do8(REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h24);
    do8(ADD, 3'd0, 3'd1, 3'd2, 8'h00);
    rd8(3'd2, 8'h66, "sum_r2");
    chk("sum_carry", {63'd0, c8}, 64'd0);
    chk("sum_zero", {63'd0, z8}, 64'd0);
    idle8();
    chk("sum_ov_drop", {63'd0, ov8}, 64'd0);
    chk("sum_dout_hold", {56'd0, dout8}, 64'h66);

    // Back-to-back Fibonacci
    do8(REG_WRITE, 3'd0, 3'd0, 3'd0, 8'h00);
    do8(REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h01);
    do8(REG_WRITE, 3'd2, 3'd0, 3'd0, 8'h01);
    do8(ADD, 3'd1, 3'd2, 3'd3, 8'h00);
    do8(ADD, 3'd2, 3'd3, 3'd4, 8'h00);
    do8(ADD, 3'd3, 3'd4, 3'd5, 8'h00);
    do8(ADD, 3'd4, 3'd5, 3'd6, 8'h00);
    do8(ADD, 3'd5, 3'd6, 3'd7, 8'h00);
    rd8(3'd3, 8'h02, "fib_r3");
    rd8(3'd4, 8'h03, "fib_r4");
    rd8(3'd5, 8'h05, "fib_r5");
    rd8(3'd6, 8'h08, "fib_r6");
    rd8(3'd7, 8'h0d, "fib_r7");

    // Flags and carry bypass
    do8(REG_WRITE, 3'd0, 3'd0, 3'd0, 8'hF0);
    do8(REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h20);
    do8(REG_WRITE, 3'd2, 3'd0, 3'd0, 8'h00);
    do8(ADD, 3'd0, 3'd1, 3'd3, 8'h00);
    do8(ADC, 3'd2, 3'd2, 3'd4, 8'h00);
    chk("add_carry", {63'd0, c8}, 64'd1);
    chk("add_zero", {63'd0, z8}, 64'd0);
    idle8();
    chk("adc_carry", {63'd0, c8}, 64'd0);
    chk("adc_zero", {63'd0, z8}, 64'd0);
    rd8(3'd3, 8'h10, "add_r3");
    rd8(3'd4, 8'h01, "adc_r4");
    do8(REG_WRITE, 3'd5, 3'd0, 3'd0, 8'h05);
    do8(REG_WRITE, 3'd6, 3'd0, 3'd0, 8'h03);
    do8(SUB, 3'd5, 3'd5, 3'd7, 8'h00);
    idle8();
    chk("sub_eq_zero", {63'd0, z8}, 64'd1);
    chk("sub_eq_carry", {63'd0, c8}, 64'd0);
    do8(SUB, 3'd6, 3'd5, 3'd7, 8'h00);
    idle8();
    chk("sub_lt_carry", {63'd0, c8}, 64'd1);
    chk("sub_lt_zero", {63'd0, z8}, 64'd0);
    rd8(3'd7, 8'hFE, "sub_r7");
    chk("read_keeps_carry", {63'd0, c8}, 64'd1);

    // Logic ops
    do8(REG_WRITE, 3'd0, 3'd0, 3'd0, 8'hA5);
    do8(REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h5A);
    do8(AND, 3'd0, 3'd1, 3'd2, 8'h00);
    idle8();
    chk("and_zero", {63'd0, z8}, 64'd1);
    chk("and_carry", {63'd0, c8}, 64'd0);
    do8(OR, 3'd0, 3'd1, 3'd3, 8'h00);
    idle8();
    chk("or_zero", {63'd0, z8}, 64'd0);
    do8(ADD, 3'd0, 3'd0, 3'd5, 8'h00);
    idle8();
    chk("add_a5a5_carry", {63'd0, c8}, 64'd1);
    do8(XOR, 3'd0, 3'd1, 3'd4, 8'h00);
    idle8();
    chk("xor_carry", {63'd0, c8}, 64'd0);
    chk("xor_zero", {63'd0, z8}, 64'd0);
    rd8(3'd2, 8'h00, "and_r2");
    rd8(3'd3, 8'hFF, "or_r3");
    rd8(3'd4, 8'hFF, "xor_r4");
    rd8(3'd5, 8'h4A, "add_r5");

    // In-place op, then invalid/NOP ops must not change state
    do8(ADD, 3'd1, 3'd1, 3'd1, 8'h00);
    v8 = 1'b0; op8 = REG_WRITE; a8 = 3'd1; din8 = 8'h99;
    @(negedge clk);
    do8(NOP, 3'd1, 3'd0, 3'd0, 8'h77);
    rd8(3'd1, 8'hB4, "inplace_r1");

    // Reset in the middle of an op
    do8(REG_WRITE, 3'd0, 3'd0, 3'd0, 8'hFF);
    do8(REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h02);
    do8(ADD, 3'd0, 3'd1, 3'd6, 8'h00);
    v8 = 1'b1; op8 = ADD; a8 = 3'd0; b8 = 3'd1; r8 = 3'd4; din8 = 8'h00;
    @(posedge clk);
    #1;
    chk("pre_rst_carry", {63'd0, c8}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_dout", {56'd0, dout8}, 64'd0);
    chk("mid_rst_ov", {63'd0, ov8}, 64'd0);
    chk("mid_rst_carry", {63'd0, c8}, 64'd0);
    chk("mid_rst_zero", {63'd0, z8}, 64'd0);
    op8 = REG_WRITE; a8 = 3'd1; din8 = 8'h77;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle8();
    idle8();
    rd8(3'd4, 8'h00, "rst_no_late_r4");
    rd8(3'd6, 8'h00, "rst_cleared_r6");
    rd8(3'd1, 8'h00, "rst_ignored_r1");
    chk("post_rst_carry", {63'd0, c8}, 64'd0);

    // 16-bit instance
    do16(REG_WRITE, 4'd0, 4'd0, 4'd0, 16'hFFFF);
    do16(REG_WRITE, 4'd1, 4'd0, 4'd0, 16'h0001);
    do16(ADD, 4'd0, 4'd1, 4'd15, 16'h0000);
    idle16();
    chk("w16_carry", {63'd0, c16}, 64'd1);
    chk("w16_zero", {63'd0, z16}, 64'd1);
    rd16(4'd0, 16'hFFFF, "w16_r0");
    rd16(4'd15, 16'h0000, "w16_r15");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_regfile_pipe.md
ALU_REGFILE_PIPE -- requirements
Module: alu_regfile_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register and ALU datapath width in bits (legal 4..64).
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning register count (power of two, 2..32); ADDR_W = $clog2(NUM_REGS).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port op_valid, input, 1, meaning op and operands are presented this cycle.
REQ-006 SHALL have port op, input, constants_pkg::ALUOp, meaning operation: NOP, REG_READ, REG_WRITE, ADD, ADC, SUB, AND, OR, XOR.
REQ-007 SHALL have ports addr_a and addr_b, input, ADDR_W each, meaning source register indices; addr_a is also the target of REG_WRITE.
REQ-008 SHALL have port addr_r, input, ADDR_W, meaning destination index for ALU ops.
REQ-009 SHALL have port data_in, input, DATA_W, meaning REG_WRITE data.
REQ-010 SHALL have port data_out, output, DATA_W, meaning REG_READ result (registered, never high-Z).
REQ-011 SHALL have port out_valid, output, 1, meaning a one-cycle pulse when data_out is updated by REG_READ.
REQ-012 SHALL have ports carry_flag and zero_flag, output, 1 each, meaning registered ALU status.

Function
REQ-013 SHALL accept an op at each rising edge where op_valid=1, one op per cycle, no stalls; op_valid=0 or op=NOP SHALL change no state.
REQ-014 SHALL implement two stages: issue (operand read, latched at accepting edge N) and execute/writeback (register, flag and data_out update at edge N+1).
REQ-015 SHALL bypass: if the op in execute writes register X, an op issued that cycle reading X SHALL use the result being written, not the stale register (applies to addr_a, addr_b, REG_READ).
REQ-016 SHALL bypass carry: ADC issued immediately after a flag-updating op SHALL use that op's carry result.
REQ-017 SHALL compute ADD: r[addr_r] = (a+b) mod 2^DATA_W, carry = bit DATA_W of the full sum.
REQ-018 SHALL compute ADC: r[addr_r] = (a+b+carry_flag) mod 2^DATA_W, carry = bit DATA_W.
REQ-019 SHALL compute SUB: r[addr_r] = (a-b) mod 2^DATA_W, carry = 1 iff a < b unsigned (borrow).
REQ-020 SHALL compute AND/OR/XOR bitwise into r[addr_r], carry cleared to 0.
REQ-021 SHALL set zero_flag = (truncated DATA_W result == 0) for ADD, ADC, SUB, AND, OR, XOR; REG_READ, REG_WRITE, NOP SHALL leave both flags unchanged.
REQ-022 SHALL on REG_WRITE store data_in into r[addr_a] at edge N+1.
REQ-023 SHALL on REG_READ load data_out with r[addr_a] (bypassed) at edge N+1 and assert out_valid for exactly that cycle; data_out SHALL hold otherwise.
REQ-024 SHALL permit addr_r equal to addr_a and/or addr_b (in-place op reads old values).
REQ-025 SHALL have deterministic precedence: only the execute-stage op writes the register file; no write-write conflict exists.

Reset
REQ-026 SHALL on reset_n=0 immediately clear all registers, data_out, out_valid, carry_flag, zero_flag to 0 and discard the execute-stage op (no write).
REQ-027 SHALL ignore ops while reset_n=0; first op accepted at first rising edge with reset_n=1.

Verification
REQ-028 Basic sum: WRITE r0=0x42, WRITE r1=0x24, ADD r2=r0+r1, READ r2 -> data_out=0x66, out_valid one cycle, carry=0, zero=0.
REQ-029 Back-to-back Fibonacci, no idle cycles: r0=0,r1=1,r2=1, then ADD r3=r1+r2 ... r7=r5+r6 on consecutive cycles -> READ r3..r7 = 0x02,0x03,0x05,0x08,0x0d (bypass proven).
REQ-030 Flags: ADD 0xF0+0x20 -> 0x10, carry=1, zero=0; next-cycle ADC 0x00+0x00 -> 0x01; SUB 0x05-0x05 -> 0x00, zero=1, carry=0; SUB 0x03-0x05 -> 0xFE, carry=1.
REQ-031 Logic: r0=0xA5,r1=0x5A: AND -> 0x00 zero=1; OR -> 0xFF; XOR -> 0xFF carry=0.
REQ-032 Reset mid-op: issue ADD r4=r0+r1, assert reset_n=0 before next edge -> r4=0, all outputs 0, no late write after release.
REQ-033 Parametric: DATA_W=16, NUM_REGS=16: ADD r15=0xFFFF+0x0001 -> 0x0000, carry=1, zero=1; READ r15 -> 0x0000.
